// File: rtl/tf_filter_mc.sv
// rtl/tf_filter_mc.sv - multichannel biquad IIR filter sharing one multiplier-accumulator
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   in_valid   sample offered              in_ready   block idle and able to accept
//   in_ch      channel of offered sample   in_data    signed sample x[n]
//   out_valid  result available            out_ready  downstream accepts result
//   out_ch     channel of result           out_data   signed saturated result y[n]
//   coef_we    coefficient write strobe    coef_ch    channel of coefficient write
//   coef_idx   0=b0 1=b1 2=b2 3=a1 4=a2    coef_data  signed coefficient, FRAC_BITS fraction
//   hist_clr   clear every channel history (honoured only while idle)
module tf_filter_mc #(
    parameter int N_CH       = 2,
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 16,
    parameter int FRAC_BITS  = 14,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CH_W-1:0]              in_ch,
    input  logic signed [WIDTH-1:0]      in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH_W-1:0]              out_ch,
    output logic signed [WIDTH-1:0]      out_data,
    input  logic                         coef_we,
    input  logic [CH_W-1:0]              coef_ch,
    input  logic [2:0]                   coef_idx,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    input  logic                         hist_clr
);

    localparam int PROD_W = WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + 3;
    localparam int CH_SPAN = 1 << CH_W;

    // One bit per encodable channel number, set for channels that exist.
    localparam logic [CH_SPAN-1:0] CH_MASK = {CH_SPAN{1'b1}} >> (CH_SPAN - N_CH);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Low only until the first edge after reset, so in_ready stays low in reset.
    logic                         live_q;
    // 0..4 select the product accumulated at the next edge, 5 finalises.
    logic [2:0]                   step_q;
    logic [CH_W-1:0]              cur_ch_q;
    logic signed [WIDTH-1:0]      x_cur_q;
    logic signed [ACC_W-1:0]      acc_q;

    logic signed [COEF_WIDTH-1:0] coef_q [N_CH][5];
    logic signed [WIDTH-1:0]      x1_q [N_CH];
    logic signed [WIDTH-1:0]      x2_q [N_CH];
    logic signed [WIDTH-1:0]      y1_q [N_CH];
    logic signed [WIDTH-1:0]      y2_q [N_CH];

    logic                         accept;
    logic                         coef_ok;
    logic signed [COEF_WIDTH-1:0] mac_coef;
    logic signed [WIDTH-1:0]      mac_opnd;
    logic                         mac_sub;
    logic signed [PROD_W-1:0]     product;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W-1:0]      term;
    logic signed [ACC_W-1:0]      shifted;
    logic signed [WIDTH-1:0]      y_sat;

    assign in_ready = live_q && (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign coef_ok  = coef_we && CH_MASK[coef_ch] && (coef_idx <= 3'd4);

    // Operand selection for the shared MAC: b0*x, b1*x1, b2*x2, then a1*y1, a2*y2 subtracted.
    always_comb begin
        mac_coef = '0;
        mac_opnd = '0;
        mac_sub  = 1'b0;
        case (step_q)
            3'd0: begin
                mac_coef = coef_q[cur_ch_q][0];
                mac_opnd = x_cur_q;
            end
            3'd1: begin
                mac_coef = coef_q[cur_ch_q][1];
                mac_opnd = x1_q[cur_ch_q];
            end
            3'd2: begin
                mac_coef = coef_q[cur_ch_q][2];
                mac_opnd = x2_q[cur_ch_q];
            end
            3'd3: begin
                mac_coef = coef_q[cur_ch_q][3];
                mac_opnd = y1_q[cur_ch_q];
                mac_sub  = 1'b1;
            end
            3'd4: begin
                mac_coef = coef_q[cur_ch_q][4];
                mac_opnd = y2_q[cur_ch_q];
                mac_sub  = 1'b1;
            end
            default: ;
        endcase
    end

    assign product  = mac_coef * mac_opnd;
    assign prod_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    assign term     = mac_sub ? -prod_ext : prod_ext;

    // Arithmetic shift floors toward minus infinity; then clamp to the sample range.
    assign shifted = acc_q >>> FRAC_BITS;

    always_comb begin
        y_sat = shifted[WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            y_sat = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            y_sat = SAT_MIN[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Samples for non-existent channels are handshaken but leave the block idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && CH_MASK[in_ch]) state_d = MAC;
            MAC:  if (step_q == 3'd5) state_d = OUT;
            OUT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q    <= 1'b0;
            step_q    <= '0;
            cur_ch_q  <= '0;
            x_cur_q   <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
                for (int k = 0; k < 5; k++) begin
                    coef_q[c][k] <= '0;
                end
            end
        end else begin
            live_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    // Writes and clears land on the accepting edge, so the
                    // accepted sample's MAC already sees them.
                    if (coef_ok) begin
                        coef_q[coef_ch][coef_idx] <= coef_data;
                    end
                    if (hist_clr) begin
                        for (int c = 0; c < N_CH; c++) begin
                            x1_q[c] <= '0;
                            x2_q[c] <= '0;
                            y1_q[c] <= '0;
                            y2_q[c] <= '0;
                        end
                    end
                    if (accept) begin
                        cur_ch_q <= in_ch;
                        x_cur_q  <= in_data;
                        acc_q    <= '0;
                        step_q   <= '0;
                    end
                end
                MAC: begin
                    if (step_q != 3'd5) begin
                        acc_q  <= acc_q + term;
                        step_q <= step_q + 3'd1;
                    end else begin
                        out_data  <= y_sat;
                        out_ch    <= cur_ch_q;
                        out_valid <= 1'b1;
                        x2_q[cur_ch_q] <= x1_q[cur_ch_q];
                        x1_q[cur_ch_q] <= x_cur_q;
                        y2_q[cur_ch_q] <= y1_q[cur_ch_q];
                        y1_q[cur_ch_q] <= y_sat;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tf_filter_mc.sv
// tb/tb_tf_filter_mc.sv - randomized and directed bench for tf_filter_mc against a behavioural model
`timescale 1ns/1ps
module tb_tf_filter_mc;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [0:0]        in_ch;
    logic signed [15:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [0:0]        out_ch;
    logic signed [15:0] out_data;
    logic              coef_we;
    logic [0:0]        coef_ch;
    logic [2:0]        coef_idx;
    logic signed [15:0] coef_data;
    logic              hist_clr;

    tf_filter_mc #(
        .N_CH(2), .WIDTH(16), .COEF_WIDTH(16), .FRAC_BITS(14)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
        .coef_we(coef_we), .coef_ch(coef_ch), .coef_idx(coef_idx), .coef_data(coef_data),
        .hist_clr(hist_clr)
    );

    typedef struct {
        int     ch;
        int     d;
        longint t;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_err = 0;
    int     rdy_mode = 0;
    int     last_d = 0;
    int     last_c = 0;

    int     mc [2][5];
    int     mx1 [2];
    int     mx2 [2];
    int     my1 [2];
    int     my2 [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input longint act, input longint exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp_v, $time);
        end
    endfunction

    function automatic void clear_hist();
        for (int c = 0; c < 2; c++) begin
            mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
        end
    endfunction

    function automatic void clear_all();
        clear_hist();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 5; k++)
                mc[c][k] = 0;
    endfunction

    // Difference equation in wide integer arithmetic, floor scaling, clamp.
    function automatic int model_run(input int ch, input int x);
        longint acc;
        longint y;
        acc = longint'(mc[ch][0]) * x + longint'(mc[ch][1]) * mx1[ch]
            + longint'(mc[ch][2]) * mx2[ch] - longint'(mc[ch][3]) * my1[ch]
            - longint'(mc[ch][4]) * my2[ch];
        y = acc >>> 14;
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
        mx2[ch] = mx1[ch];
        mx1[ch] = x;
        my2[ch] = my1[ch];
        my1[ch] = int'(y);
        return int'(y);
    endfunction

    // out_ready changes just after the rising edge so it is stable at the sampling edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin : cmp
        exp_t   e;
        bit     pv;
        bit     prev_hs;
        int     held_d;
        int     held_c;
        if (!rst) begin
            pv = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) begin
                chk("resume_out_valid", out_valid, 0);
                chk("resume_in_ready", in_ready, 1);
            end
            if (out_valid) begin
                chk("busy_in_ready", in_ready, 0);
                if (!pv) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_ch", out_ch, e.ch);
                        chk("latency", longint'($time) - e.t, 65);
                    end
                    held_d = out_data;
                    held_c = out_ch;
                    last_d = out_data;
                    last_c = out_ch;
                end else begin
                    chk("hold_data", out_data, held_d);
                    chk("hold_ch", out_ch, held_c);
                end
            end
            pv = out_valid;
            prev_hs = out_valid && out_ready;
        end
    end

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, in_ready, 1);
    endtask

    task automatic wr(input int ch, input int idx, input int val);
        wait_idle("wr_wait");
        coef_we = 1'b1;
        coef_ch = ch[0:0];
        coef_idx = idx[2:0];
        coef_data = val[15:0];
        @(posedge clk);
        if (idx <= 4) mc[ch][idx] = val;
        #1 coef_we = 1'b0;
    endtask

    task automatic send(input int ch, input int x, input bit hclr = 1'b0, input bit cw = 1'b0,
                        input int cch = 0, input int cidx = 0, input int cval = 0);
        exp_t e;
        wait_idle("accept_wait");
        in_valid = 1'b1;
        in_ch = ch[0:0];
        in_data = x[15:0];
        hist_clr = hclr;
        coef_we = cw;
        coef_ch = cch[0:0];
        coef_idx = cidx[2:0];
        coef_data = cval[15:0];
        @(posedge clk);
        if (cw && cidx <= 4) mc[cch][cidx] = cval;
        if (hclr) clear_hist();
        e.ch = ch;
        e.d = model_run(ch, x);
        e.t = longint'($time);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        hist_clr = 1'b0;
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic send_chk(input int ch, input int x, input int exp_d);
        send(ch, x);
        drain();
        chk("lit_data", last_d, exp_d);
        chk("lit_ch", last_c, ch);
    endtask

    initial begin
        int r;
        rst = 1'b0;
        in_valid = 1'b0; in_ch = '0; in_data = '0;
        coef_we = 1'b0; coef_ch = '0; coef_idx = '0; coef_data = '0;
        hist_clr = 1'b0;
        out_ready = 1'b1;
        clear_all();

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_in_ready", in_ready, 0);
        #20 rst = 1'b1;
        #1 chk("ready_pre_edge", in_ready, 0);
        @(negedge clk);
        chk("ready_post_edge", in_ready, 1);

        // pass-through
        wr(0, 0, 16384);
        send_chk(0, 1000, 1000);

        // one-pole on ch1
        wr(1, 0, 8192);
        wr(1, 3, -8192);
        send_chk(1, 16384, 8192);
        send_chk(1, 16384, 12288);
        send_chk(1, 16384, 14336);

        // coefficient write and history clear while busy must be ignored
        send(0, 777);
        @(negedge clk);
        coef_we = 1'b1; coef_ch = 1'b0; coef_idx = 3'd0; coef_data = 16'sd0; hist_clr = 1'b1;
        repeat (2) @(negedge clk);
        coef_we = 1'b0; hist_clr = 1'b0;
        drain();
        chk("busy_poke_data", last_d, 777);
        send_chk(1, 16384, 15360);
        send_chk(0, -500, -500);

        // saturation
        wr(0, 0, 32767);
        send_chk(0, 32767, 32767);
        send_chk(0, -32768, -32768);

        // coefficient write coincident with accept takes effect for that sample
        send(0, 1000, 1'b0, 1'b1, 0, 0, 16384);
        drain();
        chk("coincident_coef", last_d, 1000);

        // coincident history clear and channel interleave
        send(1, 16384, 1'b1);
        drain();
        chk("coincident_clr", last_d, 8192);
        send_chk(0, 1000, 1000);
        send_chk(1, 16384, 12288);
        send_chk(0, 2000, 2000);
        send_chk(1, 16384, 14336);

        // backpressure
        rdy_mode = 1;
        send(0, 1234);
        repeat (16) @(negedge clk);
        rdy_mode = 0;
        drain();
        chk("bp_data", last_d, 1234);

        // reset mid-computation
        send(0, 5000);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_in_ready", in_ready, 0);
        clear_all();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("abort_ready_pre_edge", in_ready, 0);
        send_chk(1, 1234, 0);
        wr(0, 0, 16384);
        send_chk(0, 5000, 5000);

        // randomized traffic
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                wr($urandom_range(0, 1), $urandom_range(0, 7), int'($urandom_range(0, 40000)) - 20000);
            end else begin
                send($urandom_range(0, 1), int'($urandom_range(0, 65535)) - 32768, r < 15);
            end
        end
        rdy_mode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
